jtdsp16_fetch: RTL and testbench

- Instruction fetch stage directly downstream of the ROM address unit (XAAU).
- Takes the XAAU program counter, fetches the word from external program ROM with an ok-handshake, and presents the instruction register to the decoder.
- Splits the second word of two-word (immediate) instructions onto a separate bus.
- A small do-loop cache replays loop bodies without ROM access.
- Drives pc_halt back to the XAAU while a word is not yet available.

---
 rtl/jtdsp16_pkg.sv | 36 +++
 rtl/jtdsp16_fetch_if.sv | 30 +++
 rtl/jtdsp16_fetch_cache.sv | 97 +++++++++
 rtl/jtdsp16_fetch.sv | 108 ++++++++++
 tb/tb_jtdsp16_fetch.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtdsp16_pkg.sv
// ---------------------------------------------------------------------------
// jtdsp16_pkg
// Shared constants and helpers for the DSP16 instruction fetch stage.
//   CACHE_W_DEF : default do-loop cache depth in words (legal 1..15)
//   ROM_AW      : program ROM address width
//   DO_LEN_W    : width of the do-loop body length field (do_data[10:7])
//   WORD_W      : instruction word width
//   NOP         : instruction encoding used as the idle/reset value of ir
// ---------------------------------------------------------------------------
package jtdsp16_pkg;

    localparam int CACHE_W_DEF = 15;
    localparam int ROM_AW      = 16;
    localparam int DO_LEN_W    = 4;
    localparam int WORD_W      = 16;

    localparam logic [WORD_W-1:0] NOP = 16'h0000;

    // What a do instruction does to the loop cache
    typedef enum logic [1:0] {
        CACHE_KEEP,     // no do, or redo (len 0): cache left intact
        CACHE_LOAD,     // new loop that fits: rebase and refill
        CACHE_BYPASS    // loop too long to cache: run it from ROM
    } cache_op_e;

    function automatic cache_op_e decode_do(input logic                do_start,
                                            input logic [DO_LEN_W-1:0] do_len,
                                            input int                  depth);
        if (!do_start || do_len == '0)
            return CACHE_KEEP;
        if (int'(do_len) <= depth)
            return CACHE_LOAD;
        return CACHE_BYPASS;
    endfunction

endpackage

// File: rtl/jtdsp16_fetch_if.sv
// ---------------------------------------------------------------------------
// jtdsp16_fetch_if
// Program ROM bus between the fetch stage (master) and the ROM (slave).
//   rom_cs   : fetch requests a ROM read
//   rom_addr : ROM read address
//   rom_data : ROM read data
//   rom_ok   : rom_data is valid for the address that has been held
// ---------------------------------------------------------------------------
interface jtdsp16_fetch_if #(
    parameter int AW = 16
);
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic          rom_ok;

    modport master (
        output rom_cs,
        output rom_addr,
        input  rom_data,
        input  rom_ok
    );

    modport slave (
        input  rom_cs,
        input  rom_addr,
        output rom_data,
        output rom_ok
    );
endinterface

// File: rtl/jtdsp16_fetch_cache.sv
// ---------------------------------------------------------------------------
// jtdsp16_fetch_cache
// Do-loop cache: holds up to CACHE_W words of a loop body so that later
// passes replay without touching program ROM.
//   clk, rst_n : clock, asynchronous active-low reset
//   cen        : clock enable
//   pc         : current program address
//   do_start   : do instruction executing this cycle
//   do_len     : loop body length (0 = redo, keep cache)
//   word_ok    : the word for pc is available this cycle
//   word       : that word (cache or ROM)
//   hit        : pc lies inside the cached loop and its slot is filled
//   rd_data    : cached word for pc (meaningful only when hit)
// ---------------------------------------------------------------------------
module jtdsp16_fetch_cache
    import jtdsp16_pkg::*;
#(
    parameter int CACHE_W = CACHE_W_DEF,
    parameter int AW      = ROM_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cen,
    input  logic [AW-1:0]       pc,
    input  logic                do_start,
    input  logic [DO_LEN_W-1:0] do_len,
    input  logic                word_ok,
    input  logic [WORD_W-1:0]   word,
    output logic                hit,
    output logic [WORD_W-1:0]   rd_data
);

    // Storage is addressed by the full length field; slots at or above
    // CACHE_W are never enabled and fall away in synthesis.
    localparam int                SLOTS = 1 << DO_LEN_W;
    localparam logic [DO_LEN_W:0] DEPTH = (DO_LEN_W + 1)'(CACHE_W);

    logic [WORD_W-1:0]   mem [SLOTS];
    logic [SLOTS-1:0]    valid;
    logic [AW-1:0]       base;
    logic [AW-1:0]       offset;
    logic [DO_LEN_W-1:0] len;
    logic [DO_LEN_W-1:0] idx;
    logic                fill;
    logic                in_range;
    logic                slot_ok;
    logic                wr;
    cache_op_e           op;

    // Modular offset lets a loop straddle the top of the address space
    assign offset   = pc - base;
    assign idx      = offset[DO_LEN_W-1:0];
    assign in_range = offset < AW'(len);
    assign slot_ok  = {1'b0, idx} < DEPTH;
    assign hit      = in_range && valid[idx];
    assign rd_data  = mem[idx];
    assign op       = decode_do(do_start, do_len, CACHE_W);
    assign wr       = cen && word_ok && fill && !hit && in_range && slot_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            base  <= '0;
            len   <= '0;
            fill  <= 1'b0;
        end else if (cen) begin
            case (op)
                CACHE_LOAD: begin
                    base  <= pc;
                    len   <= do_len;
                    fill  <= 1'b1;
                    // The first body word may already arrive in the do
                    // cycle; keep it rather than losing it to the clear.
                    valid <= {{(SLOTS - 1){1'b0}}, word_ok};
                end
                CACHE_BYPASS: begin
                    fill <= 1'b0;
                    len  <= '0;
                end
                default: begin
                    if (wr)
                        valid[idx] <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cen) begin
            if (op == CACHE_LOAD && word_ok)
                mem[0] <= word;
            else if (wr)
                mem[idx] <= word;
        end
    end

endmodule

// File: rtl/jtdsp16_fetch.sv
// ---------------------------------------------------------------------------
// jtdsp16_fetch
// Instruction fetch stage sitting after the XAAU. Reads program ROM with an
// ok handshake (or replays from the do-loop cache), registers the
// instruction for the decoder, steers the second word of two-word
// instructions to imm_data, and halts the XAAU while no word is available.
//   clk, rst_n : clock, asynchronous active-low reset
//   cen        : clock enable
//   pc         : program address from the XAAU
//   do_start   : do instruction executing this cycle
//   do_len     : do body length, 0 = redo
//   imm_req    : decoder reports current ir is a two-word instruction
//   rom        : program ROM bus (master side)
//   ir         : instruction register
//   ir_valid   : ir was loaded this cycle (otherwise the decoder runs a NOP)
//   imm_data   : immediate second word
//   imm_valid  : imm_data was loaded this cycle
//   pc_halt    : word not available, XAAU must hold pc
// ---------------------------------------------------------------------------
module jtdsp16_fetch
    import jtdsp16_pkg::*;
#(
    parameter int CACHE_W = CACHE_W_DEF,
    parameter int AW      = ROM_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cen,
    input  logic [AW-1:0]       pc,
    input  logic                do_start,
    input  logic [DO_LEN_W-1:0] do_len,
    input  logic                imm_req,
    jtdsp16_fetch_if.master     rom,
    output logic [WORD_W-1:0]   ir,
    output logic                ir_valid,
    output logic [WORD_W-1:0]   imm_data,
    output logic                imm_valid,
    output logic                pc_halt
);

    logic                hit;
    logic [WORD_W-1:0]   cache_data;
    logic [WORD_W-1:0]   word;
    logic                word_ok;
    logic                addr_stable;
    logic                last_cs;
    logic [AW-1:0]       last_addr;
    logic                imm_pending;

    jtdsp16_fetch_cache #(
        .CACHE_W (CACHE_W),
        .AW      (AW)
    ) u_cache (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .pc       (pc),
        .do_start (do_start),
        .do_len   (do_len),
        .word_ok  (word_ok),
        .word     (word),
        .hit      (hit),
        .rd_data  (cache_data)
    );

    assign rom.rom_addr = pc;
    assign rom.rom_cs   = rst_n & ~hit;

    // rom_ok only counts once the request has been held on the same
    // address for a full enabled cycle.
    assign addr_stable = last_cs && (last_addr == pc);
    assign word_ok     = hit || (rom.rom_ok && addr_stable);
    assign word        = hit ? cache_data : rom.rom_data;
    assign pc_halt     = rst_n & ~word_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_cs     <= 1'b0;
            last_addr   <= '0;
            ir          <= NOP;
            ir_valid    <= 1'b0;
            imm_data    <= NOP;
            imm_valid   <= 1'b0;
            imm_pending <= 1'b0;
        end else if (cen) begin
            last_cs   <= rom.rom_cs;
            last_addr <= pc;
            if (word_ok) begin
                if (imm_pending) begin
                    // Second word of a two-word instruction: ir stays put
                    imm_data    <= word;
                    imm_valid   <= 1'b1;
                    ir_valid    <= 1'b0;
                    imm_pending <= 1'b0;
                end else begin
                    ir          <= word;
                    ir_valid    <= 1'b1;
                    imm_valid   <= 1'b0;
                    imm_pending <= ir_valid && imm_req;
                end
            end else begin
                ir_valid  <= 1'b0;
                imm_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtdsp16_fetch.sv
// ---------------------------------------------------------------------------
// tb_jtdsp16_fetch
// Table-driven bench for the fetch stage. Each vector holds the inputs for
// one clock and the hand-derived outputs: rom_cs/pc_halt during the cycle
// and ir/ir_valid/imm_data/imm_valid after the edge. Registered
// expectations go through a scoreboard queue. Cache depth is 4 so that an
// over-length do loop can be expressed in the 4-bit length field.
// ROM model: word(a) = 0xA000 + a, except 0x0031 -> 0x1234; rom_data reads
// 0xDEAD whenever rom_ok is low, so cache replays are visible.
// ---------------------------------------------------------------------------
module tb_jtdsp16_fetch;

    typedef struct {
        logic        cen;
        logic [15:0] pc;
        logic        ds;
        logic [3:0]  dl;
        logic        imr;
        logic        ok;
        logic        e_cs;
        logic        e_halt;
        logic        e_irv;
        logic [15:0] e_ir;
        logic        e_immv;
        logic [15:0] e_imm;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;
    logic [15:0] pc;
    logic        do_start;
    logic [3:0]  do_len;
    logic        imm_req;
    logic [15:0] ir;
    logic        ir_valid;
    logic [15:0] imm_data;
    logic        imm_valid;
    logic        pc_halt;

    int n_run  = 0;
    int n_fail = 0;

    vec_t tbl[$];
    vec_t seq[$];
    vec_t sb[$];

    jtdsp16_fetch_if #(.AW(16)) rom_bus ();

    jtdsp16_fetch #(
        .CACHE_W (4),
        .AW      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .pc        (pc),
        .do_start  (do_start),
        .do_len    (do_len),
        .imm_req   (imm_req),
        .rom       (rom_bus),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .imm_data  (imm_data),
        .imm_valid (imm_valid),
        .pc_halt   (pc_halt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        if (a == 16'h0031)
            return 16'h1234;
        return 16'hA000 + a;
    endfunction

    assign rom_bus.rom_data = rom_bus.rom_ok ? rom_word(rom_bus.rom_addr) : 16'hDEAD;

    function automatic vec_t mk(input int c, input int a, input int ds, input int dl,
                                input int imr, input int ok, input int ecs, input int eh,
                                input int eirv, input int eir, input int eimv, input int eim);
        vec_t v;
        v.cen    = (c != 0);
        v.pc     = a[15:0];
        v.ds     = (ds != 0);
        v.dl     = dl[3:0];
        v.imr    = (imr != 0);
        v.ok     = (ok != 0);
        v.e_cs   = (ecs != 0);
        v.e_halt = (eh != 0);
        v.e_irv  = (eirv != 0);
        v.e_ir   = eir[15:0];
        v.e_immv = (eimv != 0);
        v.e_imm  = eim[15:0];
        return v;
    endfunction

    task automatic check(input string nm, input int step, input logic [15:0] act,
                         input logic [15:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", nm, step, act, exp);
        end
    endtask

    task automatic reset_checks(input int step);
        check("rst_rom_cs", step, 16'(rom_bus.rom_cs), 16'h0);
        check("rst_pc_halt", step, 16'(pc_halt), 16'h0);
        check("rst_ir", step, ir, 16'h0000);
        check("rst_ir_valid", step, 16'(ir_valid), 16'h0);
        check("rst_imm_data", step, imm_data, 16'h0000);
        check("rst_imm_valid", step, 16'(imm_valid), 16'h0);
    endtask

    // Called just after an active edge: drive, check the cycle's
    // combinational outputs, queue the registered expectation, clock, compare.
    task automatic apply(input vec_t v, input int step);
        vec_t e;
        cen            = v.cen;
        pc             = v.pc;
        do_start       = v.ds;
        do_len         = v.dl;
        imm_req        = v.imr;
        rom_bus.rom_ok = v.ok;
        #1;
        check("rom_addr", step, rom_bus.rom_addr, v.pc);
        check("rom_cs", step, 16'(rom_bus.rom_cs), 16'(v.e_cs));
        check("pc_halt", step, 16'(pc_halt), 16'(v.e_halt));
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL scoreboard_empty step %0d: got 0 entries, expected 1", step);
        end else begin
            e = sb.pop_front();
            check("ir", step, ir, e.e_ir);
            check("ir_valid", step, 16'(ir_valid), 16'(e.e_irv));
            check("imm_data", step, imm_data, e.e_imm);
            check("imm_valid", step, 16'(imm_valid), 16'(e.e_immv));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // cen pc ds dl imr ok | cs halt irv ir immv imm
        // zero-wait ROM: one settle cycle per new address
        tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 1,  1, 1, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 1,  1, 0, 1, 16'hA000, 0, 16'h0000));
        tbl.push_back(mk(1, 16'h0001, 0, 0, 0, 1,  1, 1, 0, 16'hA000, 0, 16'h0000));
        tbl.push_back(mk(1, 16'h0001, 0, 0, 0, 1,  1, 0, 1, 16'hA001, 0, 16'h0000));
        tbl.push_back(mk(1, 16'h0002, 0, 0, 0, 1,  1, 1, 0, 16'hA001, 0, 16'h0000));
        tbl.push_back(mk(1, 16'h0002, 0, 0, 0, 1,  1, 0, 1, 16'hA002, 0, 16'h0000));
        // three wait states at 0x0010
        tbl.push_back(mk(1, 16'h0010, 0, 0, 0, 0,  1, 1, 0, 16'hA002, 0, 16'h0000));
        tbl.push_back(mk(1, 16'h0010, 0, 0, 0, 0,  1, 1, 0, 16'hA002, 0, 16'h0000));
        tbl.push_back(mk(1, 16'h0010, 0, 0, 0, 0,  1, 1, 0, 16'hA002, 0, 16'h0000));
        tbl.push_back(mk(1, 16'h0010, 0, 0, 0, 1,  1, 0, 1, 16'hA010, 0, 16'h0000));
        // address change with rom_ok held high
        tbl.push_back(mk(1, 16'h0020, 0, 0, 0, 1,  1, 1, 0, 16'hA010, 0, 16'h0000));
        tbl.push_back(mk(1, 16'h0020, 0, 0, 0, 1,  1, 0, 1, 16'hA020, 0, 16'h0000));
        tbl.push_back(mk(1, 16'h0040, 0, 0, 0, 1,  1, 1, 0, 16'hA020, 0, 16'h0000));
        tbl.push_back(mk(1, 16'h0040, 0, 0, 0, 1,  1, 0, 1, 16'hA040, 0, 16'h0000));
        // two-word instruction: imm_req while ir_valid, then 0x1234 goes to imm
        tbl.push_back(mk(1, 16'h0030, 0, 0, 0, 1,  1, 1, 0, 16'hA040, 0, 16'h0000));
        tbl.push_back(mk(1, 16'h0030, 0, 0, 0, 1,  1, 0, 1, 16'hA030, 0, 16'h0000));
        tbl.push_back(mk(1, 16'h0030, 0, 0, 1, 1,  1, 0, 1, 16'hA030, 0, 16'h0000));
        tbl.push_back(mk(1, 16'h0031, 0, 0, 0, 1,  1, 1, 0, 16'hA030, 0, 16'h0000));
        tbl.push_back(mk(1, 16'h0031, 0, 0, 0, 1,  1, 0, 0, 16'hA030, 1, 16'h1234));
        tbl.push_back(mk(1, 16'h0032, 0, 0, 0, 1,  1, 1, 0, 16'hA030, 0, 16'h1234));
        // do loop len 3 at 0x0100: first pass from ROM
        tbl.push_back(mk(1, 16'h0100, 1, 3, 0, 1,  1, 1, 0, 16'hA030, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0100, 0, 0, 0, 1,  1, 0, 1, 16'hA100, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0101, 0, 0, 0, 1,  1, 1, 0, 16'hA100, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0101, 0, 0, 0, 1,  1, 0, 1, 16'hA101, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0102, 0, 0, 0, 1,  1, 1, 0, 16'hA101, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0102, 0, 0, 0, 1,  1, 0, 1, 16'hA102, 0, 16'h1234));
        // second pass from cache, ROM not ready
        tbl.push_back(mk(1, 16'h0100, 0, 0, 0, 0,  0, 0, 1, 16'hA100, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0101, 0, 0, 0, 0,  0, 0, 1, 16'hA101, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0102, 0, 0, 0, 0,  0, 0, 1, 16'hA102, 0, 16'h1234));
        // redo keeps the cache
        tbl.push_back(mk(1, 16'h0100, 1, 0, 0, 0,  0, 0, 1, 16'hA100, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0101, 0, 0, 0, 0,  0, 0, 1, 16'hA101, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0102, 0, 0, 0, 0,  0, 0, 1, 16'hA102, 0, 16'h1234));
        // leaving the loop goes back to ROM
        tbl.push_back(mk(1, 16'h0103, 0, 0, 0, 1,  1, 1, 0, 16'hA102, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0103, 0, 0, 0, 1,  1, 0, 1, 16'hA103, 0, 16'h1234));
        // loop longer than the cache runs from ROM
        tbl.push_back(mk(1, 16'h0200, 1, 5, 0, 1,  1, 1, 0, 16'hA103, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0200, 0, 0, 0, 1,  1, 0, 1, 16'hA200, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0201, 0, 0, 0, 1,  1, 1, 0, 16'hA200, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0201, 0, 0, 0, 1,  1, 0, 1, 16'hA201, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0200, 0, 0, 0, 0,  1, 1, 0, 16'hA201, 0, 16'h1234));
        // loop across 0xFFFF -> 0x0000
        tbl.push_back(mk(1, 16'hFFFF, 1, 2, 0, 1,  1, 1, 0, 16'hA201, 0, 16'h1234));
        tbl.push_back(mk(1, 16'hFFFF, 0, 0, 0, 1,  1, 0, 1, 16'h9FFF, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 1,  1, 1, 0, 16'h9FFF, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 1,  1, 0, 1, 16'hA000, 0, 16'h1234));
        tbl.push_back(mk(1, 16'hFFFF, 0, 0, 0, 0,  0, 0, 1, 16'h9FFF, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 0,  0, 0, 1, 16'hA000, 0, 16'h1234));
        // do_start while the first body word is ready: entry 0 survives clear
        tbl.push_back(mk(1, 16'h0300, 0, 0, 0, 1,  1, 1, 0, 16'hA000, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0300, 1, 1, 0, 1,  1, 0, 1, 16'hA300, 0, 16'h1234));
        tbl.push_back(mk(1, 16'h0300, 0, 0, 0, 0,  0, 0, 1, 16'hA300, 0, 16'h1234));
        // cen low freezes state and outputs
        tbl.push_back(mk(0, 16'hFFFF, 0, 0, 0, 0,  1, 1, 1, 16'hA300, 0, 16'h1234));
        tbl.push_back(mk(1, 16'hFFFF, 0, 0, 0, 0,  1, 1, 0, 16'hA300, 0, 16'h1234));
        tbl.push_back(mk(1, 16'hFFFF, 0, 0, 0, 1,  1, 0, 1, 16'h9FFF, 0, 16'h1234));

        // reset mid-loop: fill, start pass 2, then pulse reset
        seq.push_back(mk(1, 16'h0100, 1, 3, 0, 1,  1, 1, 0, 16'h9FFF, 0, 16'h1234));
        seq.push_back(mk(1, 16'h0100, 0, 0, 0, 1,  1, 0, 1, 16'hA100, 0, 16'h1234));
        seq.push_back(mk(1, 16'h0101, 0, 0, 0, 1,  1, 1, 0, 16'hA100, 0, 16'h1234));
        seq.push_back(mk(1, 16'h0101, 0, 0, 0, 1,  1, 0, 1, 16'hA101, 0, 16'h1234));
        seq.push_back(mk(1, 16'h0102, 0, 0, 0, 1,  1, 1, 0, 16'hA101, 0, 16'h1234));
        seq.push_back(mk(1, 16'h0102, 0, 0, 0, 1,  1, 0, 1, 16'hA102, 0, 16'h1234));
        seq.push_back(mk(1, 16'h0100, 0, 0, 0, 0,  0, 0, 1, 16'hA100, 0, 16'h1234));
        // after reset: 0x0100 must come from ROM again
        seq.push_back(mk(1, 16'h0100, 0, 0, 0, 0,  1, 1, 0, 16'h0000, 0, 16'h0000));
        seq.push_back(mk(1, 16'h0100, 0, 0, 0, 0,  1, 1, 0, 16'h0000, 0, 16'h0000));
        seq.push_back(mk(1, 16'h0100, 0, 0, 0, 1,  1, 0, 1, 16'hA100, 0, 16'h0000));

        rst_n          = 1'b0;
        cen            = 1'b1;
        pc             = 16'h0000;
        do_start       = 1'b0;
        do_len         = 4'd0;
        imm_req        = 1'b0;
        rom_bus.rom_ok = 1'b0;
        #2;
        reset_checks(0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i + 1);

        for (int i = 0; i < 7; i++)
            apply(seq[i], 101 + i);

        // asynchronous reset pulse between clock edges
        pc             = 16'h0101;
        rom_bus.rom_ok = 1'b0;
        rst_n          = 1'b0;
        #2;
        reset_checks(200);
        #2;
        rst_n = 1'b1;

        for (int i = 7; i < seq.size(); i++)
            apply(seq[i], 101 + i);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
